data_bus_master: RTL and testbench

Initiator side of the data bus. Takes load/store requests from the pipeline MEM stage and drives ReadData/WriteData/DataAddr/BusIn. Waits on DataDone, then returns read data. Includes a posted-write buffer so stores do not stall the pipeline. Includes a timeout so a device that never completes cannot hang the core.

---
 rtl/data_bus_master.sv | 170 +++++++++++++++++
 tb/tb_data_bus_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_master.sv
// Data-bus initiator: posted-write FIFO, one outstanding load issued behind queued
// stores, single-strobe bus FSM with a cool-down cycle and a per-access timeout.
module data_bus_master #(
  parameter int WBUF_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        wr_err,
  input  logic        err_clr,
  output logic        busy,
  output logic        ReadData,
  output logic        WriteData,
  output logic [15:0] DataAddr,
  output logic [15:0] BusIn,
  input  logic [15:0] BusOut,
  input  logic        DataDone
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WR_ACC, RD_ACC, COOL} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;

  logic [31:0]   fifo_q [WBUF_DEPTH];
  logic [PW:0]   wptr_q, rptr_q;
  logic [31:0]   fifo_head;
  logic          fifo_empty, fifo_full;

  logic          rd_pending_q;
  logic [15:0]   rd_addr_q;
  logic          resp_valid_q, resp_err_q, wr_err_q;
  logic [15:0]   resp_rdata_q;

  logic          push, load_acc, pop;
  logic          rd_done, rd_abort, wr_abort, timed_out;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign fifo_head  = fifo_q[rptr_q[PW-1:0]];

  assign req_ready = !rd_pending_q && (!req_write || !fifo_full);
  assign push      = req_valid && req_ready && req_write;
  assign load_acc  = req_valid && req_ready && !req_write;
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pop      = 1'b0;
    rd_done  = 1'b0;
    rd_abort = 1'b0;
    wr_abort = 1'b0;
    case (state_q)
      // COOL dispatches like IDLE so back-to-back accesses cost access + one dead cycle.
      IDLE, COOL: begin
        state_d = IDLE;
        if (!fifo_empty) begin
          state_d = WR_ACC;
          addr_d  = fifo_head[31:16];
          wdata_d = fifo_head[15:0];
          cnt_d   = '0;
        end else if (rd_pending_q) begin
          state_d = RD_ACC;
          addr_d  = rd_addr_q;
          wdata_d = '0;
          cnt_d   = '0;
        end
      end
      WR_ACC: begin
        if (DataDone) begin
          pop     = 1'b1;
          state_d = COOL;
        end else if (timed_out) begin
          pop      = 1'b1;
          wr_abort = 1'b1;
          state_d  = COOL;
          cnt_d    = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RD_ACC: begin
        if (DataDone) begin
          rd_done = 1'b1;
          state_d = COOL;
        end else if (timed_out) begin
          rd_abort = 1'b1;
          state_d  = COOL;
          cnt_d    = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (push) wptr_q <= wptr_q + (PW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (PW+1)'(1);
      if (load_acc) begin
        rd_pending_q <= 1'b1;
        rd_addr_q    <= req_addr;
      end else if (rd_done || rd_abort) begin
        rd_pending_q <= 1'b0;
      end
      resp_valid_q <= rd_done || rd_abort;
      if (rd_done) begin
        resp_rdata_q <= BusOut;
        resp_err_q   <= 1'b0;
      end else if (rd_abort) begin
        resp_rdata_q <= '0;
        resp_err_q   <= 1'b1;
      end
      // A timeout in the same cycle as err_clr must not be lost.
      if (wr_abort)     wr_err_q <= 1'b1;
      else if (err_clr) wr_err_q <= 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) fifo_q[wptr_q[PW-1:0]] <= {req_addr, req_wdata};
  end

  assign ReadData   = (state_q == RD_ACC);
  assign WriteData  = (state_q == WR_ACC);
  assign DataAddr   = addr_q;
  assign BusIn      = wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign wr_err     = wr_err_q;
  assign busy       = !fifo_empty || rd_pending_q || (state_q != IDLE);

endmodule

// File: tb/tb_data_bus_master.sv
// Bench for data_bus_master: a bus device model plus a request-level model
// (store order, memory image, load results) checked every cycle against the DUT.
module tb_data_bus_master;
  localparam int DEPTH = 4;
  localparam int TMO   = 255;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        req_valid, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, wr_err, err_clr, busy;
  logic [15:0] resp_rdata;
  logic        ReadData, WriteData, DataDone;
  logic [15:0] DataAddr, BusIn, BusOut;

  typedef enum {DEV_COMB, DEV_WAIT1, DEV_STUCK} devMode_e;
  devMode_e    devMode = DEV_COMB;
  logic [15:0] devMem [0:65535];
  logic [15:0] modelMem [0:65535];
  logic        waitFlag;
  logic        preloadEn = 1'b0;
  logic [15:0] preloadAddr = 16'h0, preloadData = 16'h0;

  int cyc = 0;
  int checksTotal = 0;
  int checksPassed = 0;

  logic [31:0] expWr [$];
  logic [15:0] expRdAddr [$];
  logic [16:0] expResp [$];
  int          gapLog [$];

  logic        prevRd, prevWr, prevResp, strobeNow, strobePrev, lastRespErr;
  logic [31:0] curWr;
  logic [15:0] curRd, lastRespData;
  logic [16:0] expEntry;
  int          runHigh, runLow, lastStrobeLen, lastRespEdge, respCount = 0;
  int          acc, accLoad;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  data_bus_master #(.WBUF_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .wr_err(wr_err), .err_clr(err_clr), .busy(busy),
    .ReadData(ReadData), .WriteData(WriteData), .DataAddr(DataAddr), .BusIn(BusIn),
    .BusOut(BusOut), .DataDone(DataDone)
  );

  // Device: combinational done, done one cycle after the strobe, or never done.
  assign DataDone = (devMode == DEV_COMB)  ? (ReadData | WriteData) :
                    (devMode == DEV_WAIT1) ? ((ReadData | WriteData) && waitFlag) : 1'b0;
  assign BusOut = devMem[DataAddr];

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) waitFlag <= 1'b0;
    else         waitFlag <= (ReadData | WriteData) && !DataDone;
  end

  always @(posedge Clock) begin
    if (WriteData && DataDone) devMem[DataAddr] <= BusIn;
    else if (preloadEn)        devMem[preloadAddr] <= preloadData;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic failNote(input string name);
    checksTotal++;
    $display("[TB] FAIL %s: got no event, expected one within the cycle bound", name);
  endtask

  task automatic applyStimulus(input logic isWrite, input logic [15:0] addr, input logic [15:0] data,
                               input int maxWait, output int acceptEdge);
    acceptEdge = -1;
    req_valid = 1'b1;
    req_write = isWrite;
    req_addr  = addr;
    req_wdata = data;
    for (int i = 0; i < maxWait; i++) begin
      @(negedge Clock);
      if (req_ready) begin
        @(posedge Clock);
        #1;
        acceptEdge = cyc;
        if (isWrite) begin
          expWr.push_back({addr, data});
          modelMem[addr] = data;
        end else begin
          expRdAddr.push_back(addr);
          if (devMode == DEV_STUCK) expResp.push_back({1'b1, 16'h0000});
          else                      expResp.push_back({1'b0, modelMem[addr]});
        end
        break;
      end
    end
    req_valid = 1'b0;
    if (acceptEdge < 0) failNote("accept");
  endtask

  task automatic waitResp(input int maxCycles, input string name);
    int start = respCount;
    for (int i = 0; i < maxCycles && respCount == start; i++) begin
      @(posedge Clock);
      #1;
    end
    if (respCount == start) failNote(name);
  endtask

  task automatic waitIdle(input int maxCycles, input string name);
    for (int i = 0; i < maxCycles && busy; i++) begin
      @(posedge Clock);
      #1;
    end
    if (busy) failNote(name);
  endtask

  // Compare process: bus accesses against the store/load order, responses against the model.
  always @(negedge Clock) begin
    if (!Resetn) begin
      prevRd = 1'b0; prevWr = 1'b0; prevResp = 1'b0;
      runHigh = 0; runLow = 0;
    end else begin
      strobeNow  = ReadData | WriteData;
      strobePrev = prevRd | prevWr;
      checkOutput("oneStrobe", {31'd0, ReadData & WriteData}, 32'd0);
      if (WriteData && !prevWr) begin
        if (expWr.size() == 0) failNote("wrUnexpected");
        else curWr = expWr.pop_front();
      end
      if (WriteData) checkOutput("wrAddrData", {DataAddr, BusIn}, curWr);
      if (ReadData && !prevRd) begin
        if (expRdAddr.size() == 0) failNote("rdUnexpected");
        else curRd = expRdAddr.pop_front();
      end
      if (ReadData) checkOutput("rdAddr", {16'd0, DataAddr}, {16'd0, curRd});
      if (strobeNow) begin
        if (!strobePrev) begin gapLog.push_back(runLow); runHigh = 0; end
        runHigh++;
      end else begin
        if (strobePrev) begin lastStrobeLen = runHigh; runLow = 0; end
        runLow++;
      end
      if (resp_valid) begin
        checkOutput("respPulse", {31'd0, prevResp}, 32'd0);
        if (expResp.size() == 0) failNote("respUnexpected");
        else begin
          expEntry = expResp.pop_front();
          checkOutput("respData", {16'd0, resp_rdata}, {16'd0, expEntry[15:0]});
          checkOutput("respErr", {31'd0, resp_err}, {31'd0, expEntry[16]});
        end
        lastRespEdge = cyc;
        lastRespData = resp_rdata;
        lastRespErr  = resp_err;
        respCount++;
      end
      prevRd = ReadData;
      prevWr = WriteData;
      prevResp = resp_valid;
    end
  end

  initial begin
    Resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 16'h0; req_wdata = 16'h0; err_clr = 1'b0;

    preloadAddr = 16'h3000; preloadData = 16'h02A5; preloadEn = 1'b1;
    modelMem[16'h3000] = 16'h02A5;
    @(posedge Clock); #1 preloadEn = 1'b0;
    @(posedge Clock); #1;
    checkOutput("rstReadData", {31'd0, ReadData}, 32'd0);
    checkOutput("rstWriteData", {31'd0, WriteData}, 32'd0);
    checkOutput("rstRespValid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstWrErr", {31'd0, wr_err}, 32'd0);
    checkOutput("rstDataAddr", {16'd0, DataAddr}, 32'd0);
    @(negedge Clock) Resetn = 1'b1;
    @(posedge Clock); #1;
    checkOutput("readyAfterReset", {31'd0, req_ready}, 32'd1);

    // Combinational-done switch device: resp two edges after acceptance.
    devMode = DEV_COMB;
    applyStimulus(1'b0, 16'h3000, 16'h0, 10, acc);
    waitResp(10, "swResp");
    @(posedge Clock); #1;
    checkOutput("swLatency", lastRespEdge - acc, 32'd2);
    checkOutput("swRdata", {16'd0, lastRespData}, 32'h02A5);
    checkOutput("swStrobeLen", lastStrobeLen, 32'd1);

    // Two posted stores then a load of the first address, one-wait memory.
    devMode = DEV_WAIT1;
    gapLog.delete();
    applyStimulus(1'b1, 16'h0010, 16'h1111, 10, acc);
    applyStimulus(1'b1, 16'h0011, 16'h2222, 10, acc);
    applyStimulus(1'b0, 16'h0010, 16'h0, 10, accLoad);
    waitResp(40, "memResp");
    @(posedge Clock); #1;
    checkOutput("memRdata", {16'd0, lastRespData}, 32'h1111);
    checkOutput("memLatency", lastRespEdge - accLoad, 32'd7);
    checkOutput("memAccessCount", gapLog.size(), 32'd3);
    if (gapLog.size() == 3) begin
      checkOutput("coolGap1", gapLog[1], 32'd1);
      checkOutput("coolGap2", gapLog[2], 32'd1);
    end

    // Fill the write buffer with the device stalled; the fifth store must wait.
    devMode = DEV_STUCK;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 16'h0100 + 16'(k), 16'hA000 + 16'(k), 10, acc);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0104; req_wdata = 16'hA004;
    repeat (3) begin
      @(negedge Clock);
      checkOutput("readyFull", {31'd0, req_ready}, 32'd0);
    end
    devMode = DEV_COMB;
    applyStimulus(1'b1, 16'h0104, 16'hA004, 10, acc);
    waitIdle(40, "drainStores");
    devMode = DEV_WAIT1;
    applyStimulus(1'b0, 16'h0104, 16'h0, 10, accLoad);
    waitResp(20, "fifthResp");
    @(posedge Clock); #1;
    checkOutput("fifthRdata", {16'd0, lastRespData}, 32'hA004);
    checkOutput("waitLatency", lastRespEdge - accLoad, 32'd3);

    // Load from a dead device times out with an error response.
    devMode = DEV_STUCK;
    applyStimulus(1'b0, 16'h1000, 16'h0, 10, acc);
    waitResp(TMO + 20, "rdTimeoutResp");
    @(posedge Clock); #1;
    checkOutput("rdTimeoutStrobeLen", lastStrobeLen, 32'd255);
    checkOutput("rdTimeoutLatency", lastRespEdge - acc, 32'd256);
    checkOutput("rdTimeoutErr", {31'd0, lastRespErr}, 32'd1);
    checkOutput("rdTimeoutData", {16'd0, lastRespData}, 32'd0);

    // Store to a dead device with err_clr held: the timeout still sets wr_err.
    err_clr = 1'b1;
    applyStimulus(1'b1, 16'h0020, 16'hBEEF, 10, acc);
    for (int i = 0; i < TMO + 20 && !wr_err; i++) begin
      @(posedge Clock); #1;
    end
    err_clr = 1'b0;
    checkOutput("wrErrSetWins", {31'd0, wr_err}, 32'd1);
    checkOutput("wrErrLatency", cyc - acc, 32'd256);
    @(posedge Clock); #1;
    checkOutput("wrTimeoutStrobeLen", lastStrobeLen, 32'd255);
    checkOutput("fifoDrained", {31'd0, busy}, 32'd0);
    checkOutput("wrErrSticky", {31'd0, wr_err}, 32'd1);
    err_clr = 1'b1;
    @(posedge Clock); #1;
    err_clr = 1'b0;
    checkOutput("wrErrCleared", {31'd0, wr_err}, 32'd0);

    // Reset in the middle of a read access.
    applyStimulus(1'b0, 16'h1000, 16'h0, 10, acc);
    for (int i = 0; i < 10 && !ReadData; i++) begin
      @(posedge Clock); #1;
    end
    checkOutput("midAccessStrobe", {31'd0, ReadData}, 32'd1);
    Resetn = 1'b0;
    #1;
    checkOutput("rstMidRead", {31'd0, ReadData}, 32'd0);
    checkOutput("rstMidWrite", {31'd0, WriteData}, 32'd0);
    expWr.delete(); expRdAddr.delete(); expResp.delete();
    @(negedge Clock);
    @(negedge Clock) Resetn = 1'b1;
    @(posedge Clock); #1;
    checkOutput("rstMidReady", {31'd0, req_ready}, 32'd1);
    checkOutput("rstMidBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstMidResp", {31'd0, resp_valid}, 32'd0);
    checkOutput("rstMidAddr", {16'd0, DataAddr}, 32'd0);

    repeat (3) @(posedge Clock);
    #1;
    checkOutput("wrQueueDrained", expWr.size(), 32'd0);
    checkOutput("rdQueueDrained", expRdAddr.size(), 32'd0);
    checkOutput("respQueueDrained", expResp.size(), 32'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
